// File: rtl/uart_tx_frame.sv
// UART transmitter: baud divider, configurable data/parity/stop framing and a
// one-entry holding register so frames can run back to back with no idle gap.
module uart_tx_frame #(
  parameter int unsigned CLK_DIV   = 868,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_out,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  if ((DATA_BITS < 5) || (DATA_BITS > 9) || (STOP_BITS < 1) || (STOP_BITS > 2) ||
      (PARITY > 2) || (CLK_DIV < 2)) begin : g_param_check
    $error("uart_tx_frame: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4
  } state_e;

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 stop_idx_q;
  logic [DATA_BITS-1:0] hold_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 hold_full_q;
  logic                 par_q;
  logic                 tx_out_q;
  logic                 tx_busy_q;
  logic                 tx_done_q;

  logic bit_tick;
  logic last_stop;
  logic frame_end;
  logic load;
  logic accept;

  assign bit_tick  = (cnt_q == CNT_W'(CLK_DIV - 1));
  assign last_stop = (stop_idx_q == 1'(STOP_BITS - 1));
  assign frame_end = (state_q == S_STOP) && bit_tick && last_stop;
  // Held word moves to the shifter from idle or straight off the last stop tick.
  assign load      = hold_full_q && ((state_q == S_IDLE) || frame_end);
  assign accept    = tx_valid && !hold_full_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      stop_idx_q  <= 1'b0;
      hold_q      <= '0;
      shift_q     <= '0;
      hold_full_q <= 1'b0;
      par_q       <= 1'b0;
      tx_out_q    <= 1'b1;
      tx_busy_q   <= 1'b0;
      tx_done_q   <= 1'b0;
    end else begin
      tx_done_q <= frame_end;

      if ((state_q == S_IDLE) || bit_tick) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end

      if (accept) begin
        hold_q      <= tx_data;
        hold_full_q <= 1'b1;
      end

      if (load) begin
        state_q     <= S_START;
        shift_q     <= hold_q;
        par_q       <= (^hold_q) ^ (PARITY == 2);
        hold_full_q <= 1'b0;
        tx_out_q    <= 1'b0;
        tx_busy_q   <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            tx_out_q  <= 1'b1;
            tx_busy_q <= 1'b0;
          end
          S_START: begin
            if (bit_tick) begin
              state_q  <= S_DATA;
              tx_out_q <= shift_q[0];
              shift_q  <= shift_q >> 1;
              idx_q    <= '0;
            end
          end
          S_DATA: begin
            if (bit_tick) begin
              if (idx_q == IDX_W'(DATA_BITS - 1)) begin
                if (PARITY != 0) begin
                  state_q  <= S_PAR;
                  tx_out_q <= par_q;
                end else begin
                  state_q    <= S_STOP;
                  tx_out_q   <= 1'b1;
                  stop_idx_q <= 1'b0;
                end
              end else begin
                tx_out_q <= shift_q[0];
                shift_q  <= shift_q >> 1;
                idx_q    <= idx_q + 1'b1;
              end
            end
          end
          S_PAR: begin
            if (bit_tick) begin
              state_q    <= S_STOP;
              tx_out_q   <= 1'b1;
              stop_idx_q <= 1'b0;
            end
          end
          S_STOP: begin
            if (bit_tick) begin
              if (last_stop) begin
                state_q   <= S_IDLE;
                tx_out_q  <= 1'b1;
                tx_busy_q <= 1'b0;
              end else begin
                stop_idx_q <= 1'b1;
              end
            end
          end
          default: begin
            state_q   <= S_IDLE;
            tx_out_q  <= 1'b1;
            tx_busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign tx_ready = ~hold_full_q;
  assign tx_out   = tx_out_q;
  assign tx_busy  = tx_busy_q;
  assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: three framings at CLK_DIV=4, line decoded
// by a negedge monitor against hand-computed frames queued at stimulus time.
module tb_uart_tx_frame;

  localparam int DIV = 4;

  typedef struct {
    int          nbits;
    logic [15:0] bits;   // line level of bit i, start bit at index 0
  } frame_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst  [3];
  logic       vld  [3];
  logic       rdy  [3];
  logic       txo  [3];
  logic       busy [3];
  logic       done [3];
  logic [7:0] d0;
  logic [6:0] d1;
  logic [6:0] d2;

  uart_tx_frame #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .reset(rst[0]), .tx_data(d0), .tx_valid(vld[0]), .tx_ready(rdy[0]),
    .tx_out(txo[0]), .tx_busy(busy[0]), .tx_done(done[0]));

  uart_tx_frame #(.CLK_DIV(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) u1 (
    .clk(clk), .reset(rst[1]), .tx_data(d1), .tx_valid(vld[1]), .tx_ready(rdy[1]),
    .tx_out(txo[1]), .tx_busy(busy[1]), .tx_done(done[1]));

  uart_tx_frame #(.CLK_DIV(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u2 (
    .clk(clk), .reset(rst[2]), .tx_data(d2), .tx_valid(vld[2]), .tx_ready(rdy[2]),
    .tx_out(txo[2]), .tx_busy(busy[2]), .tx_done(done[2]));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  frame_t      exp_q [3][$];
  frame_t      cur [3];
  int          pos [3]         = '{-1, -1, -1};
  int          bad [3]         = '{0, 0, 0};
  int          idle_bad [3]    = '{0, 0, 0};
  int          start_cyc [3]   = '{0, 0, 0};
  int          prev_start [3]  = '{0, 0, 0};
  int          frames_seen [3] = '{0, 0, 0};
  logic [15:0] obs [3];
  bit          mon_off [3]     = '{1'b1, 1'b1, 1'b1};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  function automatic frame_t mk(input int n, input logic [15:0] b);
    frame_t f;
    f.nbits = n;
    f.bits  = b;
    return f;
  endfunction

  // Line monitor: decode frames, check every sample of each bit and the done pulse.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (mon_off[k]) begin
        pos[k] = -1;
      end else begin
        if (pos[k] == -2) begin
          check(done[k] === 1'b1, $sformatf("done_pulse_u%0d", k), int'(done[k]), 1);
          pos[k] = -1;
        end else if (pos[k] == -1 && done[k] !== 1'b0) begin
          idle_bad[k]++;
        end
        if (pos[k] == -1) begin
          if (txo[k] === 1'b0) begin
            if (exp_q[k].size() == 0) begin
              check(1'b0, $sformatf("unexpected_frame_u%0d", k), cyc, 0);
            end else begin
              cur[k]        = exp_q[k].pop_front();
              pos[k]        = 0;
              bad[k]        = 0;
              obs[k]        = '0;
              prev_start[k] = start_cyc[k];
              start_cyc[k]  = cyc;
            end
          end else if (busy[k] !== 1'b0) begin
            idle_bad[k]++;
          end
        end
        if (pos[k] >= 0) begin
          int b;
          b = pos[k] / DIV;
          obs[k][b] = txo[k];
          if (txo[k] !== cur[k].bits[b] || busy[k] !== 1'b1 ||
              (pos[k] > 0 && done[k] !== 1'b0)) bad[k]++;
          pos[k]++;
          if (pos[k] == cur[k].nbits * DIV) begin
            check(bad[k] == 0, $sformatf("frame_u%0d", k), int'(obs[k]), int'(cur[k].bits));
            frames_seen[k]++;
            pos[k] = -2;
          end
        end
      end
    end
  end

  task automatic set_data(input int k, input logic [8:0] d);
    case (k)
      0:       d0 = d[7:0];
      1:       d1 = d[6:0];
      default: d2 = d[6:0];
    endcase
  endtask

  task automatic send(input int k, input logic [8:0] d, input bit push, input frame_t f,
                      output int acc_cyc);
    int n;
    n = 0;
    if (push) exp_q[k].push_back(f);
    @(negedge clk);
    set_data(k, d);
    vld[k] = 1'b1;
    while (rdy[k] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(n < 200, $sformatf("accept_timeout_u%0d", k), n, 200);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    vld[k]  = 1'b0;
    set_data(k, ~d);
  endtask

  task automatic wait_done(input int k);
    int n;
    n = 0;
    while ((exp_q[k].size() != 0 || pos[k] != -1) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check(n < 1000, $sformatf("drain_timeout_u%0d", k), n, 1000);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual cycle %0d required finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, a3;
    int idle_err [3];
    int low_cnt;
    frame_t none;
    none = mk(0, 16'h0);
    d0 = '0;
    d1 = '0;
    d2 = '0;
    for (int k = 0; k < 3; k++) begin
      rst[k]      = 1'b1;
      vld[k]      = 1'b0;
      idle_err[k] = 0;
    end

    // Reset with no traffic: idle levels for 100 cycles, reset released after 5.
    @(posedge clk);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++)
        if (txo[k] !== 1'b1 || rdy[k] !== 1'b1 || busy[k] !== 1'b0 || done[k] !== 1'b0)
          idle_err[k]++;
      if (c == 4) for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    end
    for (int k = 0; k < 3; k++) begin
      check(idle_err[k] == 0, $sformatf("reset_idle_u%0d", k), idle_err[k], 0);
      mon_off[k] = 1'b0;
    end

    // 8N1 single frame.
    send(0, 9'h0A5, 1'b1, mk(10, 16'({1'b1, 8'hA5, 1'b0})), a1);
    wait_done(0);

    // 7E1 and 7O2 framings.
    send(1, 9'h055, 1'b1, mk(10, 16'({1'b1, 1'b0, 7'h55, 1'b0})), a1);
    send(2, 9'h055, 1'b1, mk(11, 16'({2'b11, 1'b1, 7'h55, 1'b0})), a1);
    send(1, 9'h007, 1'b1, mk(10, 16'({1'b1, 1'b1, 7'h07, 1'b0})), a1);
    send(2, 9'h000, 1'b1, mk(11, 16'({2'b11, 1'b1, 7'h00, 1'b0})), a1);
    wait_done(1);
    wait_done(2);

    // Back to back, then a third word offered while the holding register is full.
    send(0, 9'h000, 1'b1, mk(10, 16'({1'b1, 8'h00, 1'b0})), a1);
    send(0, 9'h0FF, 1'b1, mk(10, 16'({1'b1, 8'hFF, 1'b0})), a2);
    check(rdy[0] === 1'b0, "ready_low_when_full", int'(rdy[0]), 0);
    send(0, 9'h05A, 1'b1, mk(10, 16'({1'b1, 8'h5A, 1'b0})), a3);
    check(a3 == start_cyc[0] + 1, "third_accept_cycle", a3, start_cyc[0] + 1);
    check(start_cyc[0] - prev_start[0] == 10 * DIV, "no_idle_gap",
          start_cyc[0] - prev_start[0], 10 * DIV);
    wait_done(0);

    // Reset mid-DATA with a word pending in the holding register.
    mon_off[0] = 1'b1;
    send(0, 9'h03C, 1'b0, none, a1);
    send(0, 9'h099, 1'b0, none, a2);
    repeat (3 * DIV) @(negedge clk);
    check(busy[0] === 1'b1 && rdy[0] === 1'b0, "busy_before_abort",
          int'({busy[0], rdy[0]}), 2);
    rst[0] = 1'b1;
    @(posedge clk);
    #1;
    check(txo[0] === 1'b1, "abort_tx_out", int'(txo[0]), 1);
    check(rdy[0] === 1'b1, "abort_ready", int'(rdy[0]), 1);
    check(busy[0] === 1'b0, "abort_busy", int'(busy[0]), 0);
    check(done[0] === 1'b0, "abort_done", int'(done[0]), 0);
    @(negedge clk);
    rst[0]     = 1'b0;
    mon_off[0] = 1'b0;
    low_cnt    = 0;
    repeat (100) begin
      @(negedge clk);
      if (txo[0] !== 1'b1) low_cnt++;
    end
    check(low_cnt == 0, "pending_word_dropped", low_cnt, 0);

    check(frames_seen[0] == 4, "frames_u0", frames_seen[0], 4);
    check(frames_seen[1] == 2, "frames_u1", frames_seen[1], 2);
    check(frames_seen[2] == 2, "frames_u2", frames_seen[2], 2);
    for (int k = 0; k < 3; k++) begin
      check(idle_bad[k] == 0, $sformatf("idle_outputs_u%0d", k), idle_bad[k], 0);
      check(exp_q[k].size() == 0, $sformatf("queue_empty_u%0d", k), exp_q[k].size(), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
